mc_control_unit: RTL

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_control_unit.sv | 319 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mc_control_unit.sv
// Multi-cycle control unit for an RV32I-style datapath.
//
// Sequences each instruction through FETCH -> DECODE -> EXECUTE -> [MEMORY] -> [WRITEBACK]
// and drives the datapath strobes for each step. Illegal opcodes land in an absorbing TRAP
// state that only reset leaves.
//
// Optional feature: define MEM_TIMEOUT_EN to bound the FETCH/MEMORY handshake waits to
// MEM_WAIT_MAX cycles (timeout traps with bus_error). Without it, waits are unbounded and
// bus_error is tied low.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   instr_in, imem_ack   fetched instruction and fetch-complete handshake
//   imem_req             instruction fetch request
//   dmem_req, dmem_ack   data access request / completion
//   branch_taken         ALU compare result, used in EXECUTE for branches
//   ir_out               latched instruction register
//   alu_op, imm_en, sign_extender_en, sign_extender_type
//                        decode outputs, valid DECODE..WRITEBACK, 0 otherwise
//   rf_write_en, mem_read_en, mem_write_en, pc_write_en, pc_control
//                        per-state datapath strobes (pc_control 00 whenever pc_write_en=0)
//   state                current FSM state encoding
//   illegal_instr, bus_error
//                        sticky trap cause flags
module mc_control_unit #(
  parameter int unsigned IR_W         = 32,
  parameter int unsigned MEM_WAIT_MAX = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IR_W-1:0] instr_in,
  output logic            imem_req,
  input  logic            imem_ack,
  output logic            dmem_req,
  input  logic            dmem_ack,
  input  logic            branch_taken,
  output logic [IR_W-1:0] ir_out,
  output logic            imm_en,
  output logic            rf_write_en,
  output logic            mem_read_en,
  output logic            mem_write_en,
  output logic            sign_extender_en,
  output logic            sign_extender_type,
  output logic [3:0]      alu_op,
  output logic [1:0]      pc_control,
  output logic            pc_write_en,
  output logic [2:0]      state,
  output logic            illegal_instr,
  output logic            bus_error
);

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMemory    = 3'd3,
    StWriteback = 3'd4,
    StTrap      = 3'd5
  } state_e;

  // Major opcodes, ir[6:2]
  localparam logic [4:0] OpcLoad   = 5'b00000;
  localparam logic [4:0] OpcOpImm  = 5'b00100;
  localparam logic [4:0] OpcAuipc  = 5'b00101;
  localparam logic [4:0] OpcStore  = 5'b01000;
  localparam logic [4:0] OpcOp     = 5'b01100;
  localparam logic [4:0] OpcLui    = 5'b01101;
  localparam logic [4:0] OpcBranch = 5'b11000;
  localparam logic [4:0] OpcJalr   = 5'b11001;
  localparam logic [4:0] OpcJal    = 5'b11011;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluSll = 4'b0010;
  localparam logic [3:0] AluSrl = 4'b0100;
  localparam logic [3:0] AluSra = 4'b0101;
  localparam logic [3:0] AluXor = 4'b0110;
  localparam logic [3:0] AluOr  = 4'b0111;
  localparam logic [3:0] AluAnd = 4'b1000;
  localparam logic [3:0] AluBeq = 4'b1001;
  localparam logic [3:0] AluBne = 4'b1010;
  localparam logic [3:0] AluBlt = 4'b1011;
  localparam logic [3:0] AluBge = 4'b1100;
  localparam logic [3:0] AluSlt = 4'b1101;

  localparam logic [1:0] PcHold   = 2'b00;
  localparam logic [1:0] PcNext   = 2'b01;
  localparam logic [1:0] PcJump   = 2'b10;
  localparam logic [1:0] PcBranch = 2'b11;

  state_e          state_q;
  logic [IR_W-1:0] ir_q;
  logic            imem_req_q;
  logic            dmem_req_q;
  logic            illegal_q;
  logic            timeout;

  // ---------------------------------------------------------------------------------------------
  // Instruction classification
  // ---------------------------------------------------------------------------------------------
  logic [4:0] opc;
  logic [2:0] funct3;
  logic       alt;
  logic       is_load, is_store, is_branch, is_jump, is_op, legal;

  assign opc    = ir_q[6:2];
  assign funct3 = ir_q[14:12];
  assign alt    = ir_q[30];

  always_comb begin
    is_load   = (opc == OpcLoad);
    is_store  = (opc == OpcStore);
    is_branch = (opc == OpcBranch);
    is_jump   = (opc == OpcJal) || (opc == OpcJalr);
    is_op     = (opc == OpcOp);
    legal     = (ir_q[1:0] == 2'b11) &&
                (is_load || is_store || is_branch || is_jump || is_op ||
                 (opc == OpcOpImm) || (opc == OpcLui) || (opc == OpcAuipc));
  end

  // ---------------------------------------------------------------------------------------------
  // Decode outputs (combinational from IR, gated by state below)
  // ---------------------------------------------------------------------------------------------
  logic [3:0] dec_alu;
  logic       dec_imm;
  logic       dec_uns;
  logic       dec_valid;

  always_comb begin
    dec_alu = AluAdd;
    dec_imm = 1'b0;
    dec_uns = 1'b0;
    if (legal) begin
      dec_imm = !is_op;
      unique case (opc)
        OpcOpImm, OpcOp: begin
          unique case (funct3)
            3'b000:  dec_alu = (is_op && alt) ? AluSub : AluAdd;  // addi never subtracts
            3'b001:  dec_alu = AluSll;
            3'b010:  dec_alu = AluSlt;
            3'b011: begin
              dec_alu = AluSlt;
              dec_uns = 1'b1;
            end
            3'b100:  dec_alu = AluXor;
            3'b101:  dec_alu = alt ? AluSra : AluSrl;
            3'b110:  dec_alu = AluOr;
            default: dec_alu = AluAnd;
          endcase
        end
        OpcBranch: begin
          case (funct3)
            3'b000:  dec_alu = AluBeq;
            3'b001:  dec_alu = AluBne;
            3'b100:  dec_alu = AluBlt;
            3'b101:  dec_alu = AluBge;
            3'b110: begin
              dec_alu = AluBlt;
              dec_uns = 1'b1;
            end
            3'b111: begin
              dec_alu = AluBge;
              dec_uns = 1'b1;
            end
            default: dec_alu = AluAdd;
          endcase
        end
        OpcLoad: dec_uns = (funct3 == 3'b100) || (funct3 == 3'b101);  // lbu, lhu
        default: ;
      endcase
    end
  end

  assign dec_valid = (state_q == StDecode) || (state_q == StExecute) ||
                     (state_q == StMemory) || (state_q == StWriteback);

  assign alu_op             = dec_valid ? dec_alu : 4'b0000;
  assign imm_en             = dec_valid & dec_imm;
  assign sign_extender_en   = dec_valid & dec_imm;
  assign sign_extender_type = dec_valid & dec_uns;

  // ---------------------------------------------------------------------------------------------
  // Per-state datapath strobes
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    rf_write_en  = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    pc_write_en  = 1'b0;
    pc_control   = PcHold;
    unique case (state_q)
      StExecute: begin
        if (is_branch) begin
          pc_write_en = 1'b1;
          pc_control  = branch_taken ? PcBranch : PcNext;
        end
      end
      StMemory: begin
        mem_read_en  = is_load;
        mem_write_en = is_store;
        // A store retires on the ack edge, so the PC advances in that same cycle
        if (is_store && dmem_ack) begin
          pc_write_en = 1'b1;
          pc_control  = PcNext;
        end
      end
      StWriteback: begin
        rf_write_en = 1'b1;
        pc_write_en = 1'b1;
        pc_control  = is_jump ? PcJump : PcNext;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Optional handshake timeout
  // ---------------------------------------------------------------------------------------------
`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;

  logic [CntW-1:0] wait_cnt_q;
  logic            bus_error_q;
  logic            waiting;

  // The first FETCH cycle after reset has no request outstanding, so it is not a wait
  assign waiting   = ((state_q == StFetch) && imem_req_q && !imem_ack) ||
                     ((state_q == StMemory) && !dmem_ack);
  assign timeout   = waiting && (wait_cnt_q == CntW'(MEM_WAIT_MAX - 1));
  assign bus_error = bus_error_q;
`else
  assign timeout   = 1'b0;
  assign bus_error = 1'b0;
`endif

  // ---------------------------------------------------------------------------------------------
  // FSM with registered handshake requests
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StFetch;
      ir_q       <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      illegal_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q  <= '0;
      bus_error_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StFetch: begin
          if (imem_req_q && imem_ack) begin
            ir_q       <= instr_in;
            imem_req_q <= 1'b0;
            state_q    <= StDecode;
          end else if (timeout) begin
            imem_req_q <= 1'b0;
            state_q    <= StTrap;
          end else begin
            imem_req_q <= 1'b1;
          end
        end
        StDecode: begin
          if (legal) begin
            state_q <= StExecute;
          end else begin
            illegal_q <= 1'b1;
            state_q   <= StTrap;
          end
        end
        StExecute: begin
          if (is_load || is_store) begin
            dmem_req_q <= 1'b1;
            state_q    <= StMemory;
          end else if (is_branch) begin
            imem_req_q <= 1'b1;
            state_q    <= StFetch;
          end else begin
            state_q <= StWriteback;
          end
        end
        StMemory: begin
          if (dmem_ack) begin
            dmem_req_q <= 1'b0;
            if (is_load) begin
              state_q <= StWriteback;
            end else begin
              imem_req_q <= 1'b1;
              state_q    <= StFetch;
            end
          end else if (timeout) begin
            dmem_req_q <= 1'b0;
            state_q    <= StTrap;
          end
        end
        StWriteback: begin
          imem_req_q <= 1'b1;
          state_q    <= StFetch;
        end
        default: ;  // StTrap absorbs until reset
      endcase
`ifdef MEM_TIMEOUT_EN
      // Counter only survives while the FSM is still waiting in the same state
      wait_cnt_q <= (waiting && !timeout) ? wait_cnt_q + CntW'(1) : '0;
      if (timeout) begin
        bus_error_q <= 1'b1;
      end
`endif
    end
  end

  assign imem_req      = imem_req_q;
  assign dmem_req      = dmem_req_q;
  assign ir_out        = ir_q;
  assign state         = state_q;
  assign illegal_instr = illegal_q;

endmodule
